// File: rtl/keycode_event_queue_if.sv
// Event-queue port bundle: keyboard snapshot inputs, frame strobe, and the
// valid/ready event stream toward game logic.
interface keycode_event_queue_if #(
   parameter int NUM_KEYS = 6,
   parameter int KEY_W    = 8
);
   logic                      frame_clk;
   logic [NUM_KEYS*KEY_W-1:0] keycodes;
   logic                      repeat_en;
   logic                      ev_ready;
   logic                      ev_valid;
   logic [KEY_W-1:0]          ev_code;
   logic [1:0]                ev_type;
   logic                      overflow;
   logic                      overflow_clr;
   logic [3:0]                held_count;

   modport master (
      input  frame_clk, keycodes, repeat_en, ev_ready, overflow_clr,
      output ev_valid, ev_code, ev_type, overflow, held_count
   );

   modport slave (
      output frame_clk, keycodes, repeat_en, ev_ready, overflow_clr,
      input  ev_valid, ev_code, ev_type, overflow, held_count
   );
endinterface

// File: rtl/keycode_event_queue.sv
// Per-frame keycode snapshot differ: emits press/release/repeat events into a
// show-ahead FIFO so game logic consumes discrete key events.
module keycode_event_queue #(
   parameter int NUM_KEYS     = 6,
   parameter int KEY_W        = 8,
   parameter int FIFO_DEPTH   = 8,
   parameter int REPEAT_DELAY = 30,
   parameter int REPEAT_RATE  = 6
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   keycode_event_queue_if.master bus
);
   localparam int KW    = NUM_KEYS * KEY_W;
   localparam int IDX_W = $clog2(NUM_KEYS + 1);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;
   localparam int RMAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RC_W  = $clog2(RMAX + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
   localparam logic [KEY_W-1:0] ZERO_KEY = {KEY_W{1'b0}};
   localparam logic [KEY_W-1:0] ROLLOVER = KEY_W'(1'b1);
   localparam logic [1:0] EV_PRESS   = 2'b00;
   localparam logic [1:0] EV_RELEASE = 2'b01;
   localparam logic [1:0] EV_REPEAT  = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_REL, S_PRS, S_RPT, S_COMMIT} state_t;

   function automatic logic f_in_set(input logic [KEY_W-1:0] code, input logic [KW-1:0] set);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) hit = hit | (set[k*KEY_W +: KEY_W] == code);
      return hit;
   endfunction

   function automatic logic f_dup_below(input logic [KEY_W-1:0] code, input logic [KW-1:0] set,
                                        input logic [IDX_W-1:0] idx);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < NUM_KEYS; k++)
         hit = hit | ((IDX_W'(k) < idx) && (set[k*KEY_W +: KEY_W] == code));
      return hit;
   endfunction

   function automatic logic [3:0] f_count_nz(input logic [KW-1:0] set);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int k = 0; k < NUM_KEYS; k++) cnt = cnt + {3'b000, (set[k*KEY_W +: KEY_W] != ZERO_KEY)};
      return cnt;
   endfunction

   logic             r_rst_s1, r_rst_s2, w_rst_n;
   logic             r_fs1, r_fs2, r_fs3, w_tick, w_start, w_phantom, r_pending;
   state_t           r_state, w_state_nxt;
   logic [KW-1:0]    r_cur, r_prev;
   logic [IDX_W-1:0] r_idx;
   logic [KEY_W-1:0] r_rpt_code, w_prev_slot, w_cur_slot;
   logic [RC_W-1:0]  r_rpt_cnt;
   logic             r_rpt_ld, w_rpt_present, w_rpt_active;
   logic [3:0]       r_held;
   logic             w_push;
   logic [KEY_W-1:0] w_push_code;
   logic [1:0]       w_push_type;

   logic [KEY_W-1:0] r_mem_code [FIFO_DEPTH];
   logic [1:0]       r_mem_type [FIFO_DEPTH];
   logic [AW-1:0]    r_rd, r_wr, w_rd_nxt;
   logic [CW-1:0]    r_count, w_count_nxt;
   logic             w_pop, w_full, w_wr_en, w_drop;
   logic             r_valid, r_overflow;
   logic [KEY_W-1:0] r_head_code, w_head_code;
   logic [1:0]       r_head_type, w_head_type;

   // Reset asserts asynchronously and releases on a clock edge.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) {r_rst_s2, r_rst_s1} <= 2'b00;
      else          {r_rst_s2, r_rst_s1} <= {r_rst_s1, 1'b1};
   end
   assign w_rst_n = r_rst_s2;

   // Bring VGA_VS into the Clk domain and keep one delayed copy for edge detect.
   always_ff @(posedge Clk or negedge w_rst_n) begin
      if (!w_rst_n) {r_fs3, r_fs2, r_fs1} <= 3'b000;
      else          {r_fs3, r_fs2, r_fs1} <= {r_fs2, r_fs1, bus.frame_clk};
   end

   assign w_tick        = r_fs2 & ~r_fs3;
   assign w_start       = (r_state == S_IDLE) & (w_tick | r_pending);
   assign w_phantom     = f_in_set(ROLLOVER, bus.keycodes);
   assign w_prev_slot   = r_prev[int'(r_idx)*KEY_W +: KEY_W];
   assign w_cur_slot    = r_cur[int'(r_idx)*KEY_W +: KEY_W];
   assign w_rpt_present = f_in_set(r_rpt_code, r_cur);
   assign w_rpt_active  = (r_rpt_code != ZERO_KEY) & w_rpt_present;

   // A tick arriving mid-scan is remembered once and served from IDLE.
   always_ff @(posedge Clk or negedge w_rst_n) begin
      if (!w_rst_n)                r_pending <= 1'b0;
      else if (r_state == S_IDLE)  r_pending <= 1'b0;
      else if (w_tick)             r_pending <= 1'b1;
      else                         r_pending <= r_pending;
   end

   // FSM state register.
   always_ff @(posedge Clk or negedge w_rst_n) begin
      if (!w_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // FSM next-state: a snapshot holding the rollover code never starts a scan.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_start && !w_phantom) w_state_nxt = S_REL; else w_state_nxt = S_IDLE;
         S_REL:    if (r_idx == LAST_IDX) w_state_nxt = S_PRS; else w_state_nxt = S_REL;
         S_PRS:    if (r_idx == LAST_IDX) w_state_nxt = S_RPT; else w_state_nxt = S_PRS;
         S_RPT:    w_state_nxt = S_COMMIT;
         S_COMMIT: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: at most one event push per cycle.
   always_comb begin
      w_push      = 1'b0;
      w_push_code = ZERO_KEY;
      w_push_type = EV_PRESS;
      case (r_state)
         S_REL:
            if (w_prev_slot != ZERO_KEY && !f_in_set(w_prev_slot, r_cur) &&
                !f_dup_below(w_prev_slot, r_prev, r_idx)) begin
               w_push = 1'b1; w_push_code = w_prev_slot; w_push_type = EV_RELEASE;
            end else w_push = 1'b0;
         S_PRS:
            if (w_cur_slot != ZERO_KEY && !f_in_set(w_cur_slot, r_prev) &&
                !f_dup_below(w_cur_slot, r_cur, r_idx)) begin
               w_push = 1'b1; w_push_code = w_cur_slot; w_push_type = EV_PRESS;
            end else w_push = 1'b0;
         S_RPT:
            if (w_rpt_active && !r_rpt_ld && bus.repeat_en && r_rpt_cnt == RC_W'(1'b1)) begin
               w_push = 1'b1; w_push_code = r_rpt_code; w_push_type = EV_REPEAT;
            end else w_push = 1'b0;
         default: w_push = 1'b0;
      endcase
   end

   // Scan datapath: snapshot, slot index, typematic state, committed snapshot.
   always_ff @(posedge Clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_cur <= {KW{1'b0}}; r_prev <= {KW{1'b0}}; r_idx <= {IDX_W{1'b0}};
         r_rpt_code <= ZERO_KEY; r_rpt_cnt <= {RC_W{1'b0}}; r_rpt_ld <= 1'b0; r_held <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE:
               if (w_start) begin
                  r_cur <= bus.keycodes; r_idx <= {IDX_W{1'b0}}; r_rpt_ld <= 1'b0;
               end
            S_REL: r_idx <= (r_idx == LAST_IDX) ? {IDX_W{1'b0}} : r_idx + IDX_ONE;
            S_PRS: begin
               r_idx <= (r_idx == LAST_IDX) ? {IDX_W{1'b0}} : r_idx + IDX_ONE;
               if (w_push) begin
                  r_rpt_code <= w_push_code; r_rpt_cnt <= RC_W'(REPEAT_DELAY); r_rpt_ld <= 1'b1;
               end
            end
            S_RPT:
               if (r_rpt_code != ZERO_KEY && !w_rpt_present) r_rpt_code <= ZERO_KEY;
               else if (w_rpt_active && !r_rpt_ld && bus.repeat_en)
                  r_rpt_cnt <= (r_rpt_cnt == RC_W'(1'b1)) ? RC_W'(REPEAT_RATE) : r_rpt_cnt - RC_W'(1'b1);
            S_COMMIT: begin
               r_prev <= r_cur; r_held <= f_count_nz(r_cur);
            end
            default: r_idx <= {IDX_W{1'b0}};
         endcase
      end
   end

   assign w_pop       = r_valid & bus.ev_ready;
   assign w_full      = (r_count == CW'(FIFO_DEPTH));
   assign w_wr_en     = w_push & (~w_full | w_pop);
   assign w_drop      = w_push & w_full & ~w_pop;
   assign w_count_nxt = r_count + CW'(w_wr_en) - CW'(w_pop);
   assign w_rd_nxt    = r_rd + AW'(w_pop);

   // Next head: bypass the entry being written this cycle if it becomes the head.
   always_comb begin
      w_head_code = ZERO_KEY;
      w_head_type = 2'b00;
      if (w_count_nxt == {CW{1'b0}}) begin
         w_head_code = ZERO_KEY; w_head_type = 2'b00;
      end else if (w_wr_en && r_wr == w_rd_nxt) begin
         w_head_code = w_push_code; w_head_type = w_push_type;
      end else begin
         w_head_code = r_mem_code[w_rd_nxt]; w_head_type = r_mem_type[w_rd_nxt];
      end
   end

   // Event FIFO storage, pointers and registered show-ahead head.
   always_ff @(posedge Clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            r_mem_code[k] <= ZERO_KEY; r_mem_type[k] <= 2'b00;
         end
         r_rd <= {AW{1'b0}}; r_wr <= {AW{1'b0}}; r_count <= {CW{1'b0}};
         r_valid <= 1'b0; r_head_code <= ZERO_KEY; r_head_type <= 2'b00;
      end else begin
         if (w_wr_en) begin
            r_mem_code[r_wr] <= w_push_code; r_mem_type[r_wr] <= w_push_type;
            r_wr <= r_wr + AW'(1'b1);
         end
         r_rd        <= w_rd_nxt;
         r_count     <= w_count_nxt;
         r_valid     <= (w_count_nxt != {CW{1'b0}});
         r_head_code <= w_head_code;
         r_head_type <= w_head_type;
      end
   end

   // Sticky overflow; a drop wins over a simultaneous clear.
   always_ff @(posedge Clk or negedge w_rst_n) begin
      if (!w_rst_n)              r_overflow <= 1'b0;
      else if (w_drop)           r_overflow <= 1'b1;
      else if (bus.overflow_clr) r_overflow <= 1'b0;
      else                       r_overflow <= r_overflow;
   end

   assign bus.ev_valid   = r_valid;
   assign bus.ev_code    = r_head_code;
   assign bus.ev_type    = r_head_type;
   assign bus.overflow   = r_overflow;
   assign bus.held_count = r_held;
endmodule
